// File: rtl/dmem_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dmem_ctrl_pkg
// Shared definitions for the rv32is data-memory controller:
//   - memop codes (RISC-V load/store funct3 encoding)
//   - access-size and read-source enumerations
//   - default address map (RAM base, MMIO base, MMIO register offsets)
//   - helper mapping a memop to its access size
// -----------------------------------------------------------------------------
package dmem_ctrl_pkg;

  typedef enum logic [2:0] {
    MOP_B  = 3'b000,
    MOP_H  = 3'b001,
    MOP_W  = 3'b010,
    MOP_BU = 3'b100,
    MOP_HU = 3'b101
  } memop_e;

  typedef enum logic [1:0] {
    SZ_B,
    SZ_H,
    SZ_W
  } size_e;

  // Which registered value feeds the load extender.
  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_RAM,
    SRC_MMIO
  } rd_src_e;

  localparam logic [31:0] RAM_BASE_DEF  = 32'h0010_0000;
  localparam logic [31:0] MMIO_BASE_DEF = 32'h0020_0000;
  localparam logic [31:0] TIMER_OFS     = 32'h0000_0000;
  localparam logic [31:0] LED_OFS       = 32'h0000_0004;

  // Undefined codes (011/110/111) behave as word accesses.
  function automatic size_e mop_size(input logic [2:0] op);
    case (op)
      MOP_B, MOP_BU: return SZ_B;
      MOP_H, MOP_HU: return SZ_H;
      default:       return SZ_W;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ctrl_ram.sv
// -----------------------------------------------------------------------------
// dmem_ram
// WORDS x 32-bit data RAM with per-byte write enables. Writes commit on the
// rising edge of i_wrclk; reads are registered on the rising edge of i_clock.
// Contents are not reset.
// Ports:
//   i_clock  read clock
//   i_wrclk  write clock
//   i_be     byte-lane write enables (all zero = no write)
//   i_waddr  write word index
//   i_wdata  write data (lanes already steered)
//   i_raddr  read word index
//   o_rdata  registered read data
// -----------------------------------------------------------------------------
module dmem_ram #(
  parameter int unsigned WORDS = 32768,
  parameter int unsigned AW    = 15
) (
  input  logic          i_clock,
  input  logic          i_wrclk,
  input  logic [3:0]    i_be,
  input  logic [AW-1:0] i_waddr,
  input  logic [31:0]   i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [WORDS];
  logic [31:0] r_rdata;

  always_ff @(posedge i_wrclk) begin
    for (int unsigned b = 0; b < 4; b++) begin
      if (i_be[b]) begin
        r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_ctrl.sv
// -----------------------------------------------------------------------------
// dmem_ctrl
// Data-side memory controller for the single-cycle rv32is core.
// Decodes the core's data-memory port into a word RAM, a free-running timer
// (read-only) and a 32-bit LED register, performs byte/half/word stores with
// byte enables, sign/zero-extends sub-word loads and keeps a sticky error flag
// for misaligned or unmapped accesses.
// Ports:
//   clock    read clock (core dmemrdclk); timer, reset, read registers
//   reset    synchronous, active-high
//   wrclk    write clock (core dmemwrclk, ~clock); stores commit here
//   addr     byte address
//   datain   store data
//   memop    access size/sign, RISC-V funct3 encoding
//   we       store enable
//   dataout  extended load data
//   led      LED register low half
//   err      sticky access error
// -----------------------------------------------------------------------------
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned RAM_WORDS = 32768,
  parameter logic [31:0] RAM_BASE  = RAM_BASE_DEF,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        wrclk,
  input  logic [31:0] addr,
  input  logic [31:0] datain,
  input  logic [2:0]  memop,
  input  logic        we,
  output logic [31:0] dataout,
  output logic [15:0] led,
  output logic        err
);

  localparam int unsigned AW        = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS) << 2;

  // ---------------------------------------------------------------------------
  // Address decode (combinational, shared by read and write paths)
  // ---------------------------------------------------------------------------
  logic [31:0]   w_ram_off;
  logic          w_ram_hit;
  logic          w_timer_hit;
  logic          w_led_hit;
  logic          w_misal;
  logic          w_access_ok;
  logic          w_store;
  logic [AW-1:0] w_ram_idx;
  size_e         w_size;

  // Unsigned wrap makes addresses below RAM_BASE fall outside the window.
  assign w_ram_off   = addr - RAM_BASE;
  assign w_ram_hit   = (w_ram_off < RAM_BYTES);
  assign w_ram_idx   = w_ram_off[AW+1:2];
  assign w_timer_hit = (addr == (MMIO_BASE + TIMER_OFS));
  assign w_led_hit   = (addr == (MMIO_BASE + LED_OFS));
  assign w_size      = mop_size(memop);

  // MMIO registers only accept word accesses; anything narrower is
  // classed as misaligned.
  assign w_misal = ((w_size == SZ_H) && addr[0])
                || ((w_size == SZ_W) && (addr[1:0] != 2'b00))
                || ((w_timer_hit || w_led_hit) && (w_size != SZ_W));

  assign w_access_ok = (w_ram_hit || w_timer_hit || w_led_hit) && !w_misal;

  // Reset is looked at directly so a store in flight when reset rises is
  // dropped at the following wrclk edge.
  assign w_store = we && w_access_ok && !reset;

  // ---------------------------------------------------------------------------
  // Store lane steering
  // ---------------------------------------------------------------------------
  logic [3:0]  w_ram_be;
  logic [31:0] w_ram_wdata;
  logic        w_led_we;

  always_comb begin
    w_ram_be    = '0;
    w_ram_wdata = datain;
    case (w_size)
      SZ_B: begin
        w_ram_wdata = {4{datain[7:0]}};
        w_ram_be    = 4'b0001 << addr[1:0];
      end
      SZ_H: begin
        w_ram_wdata = {2{datain[15:0]}};
        w_ram_be    = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_ram_wdata = datain;
        w_ram_be    = 4'b1111;
      end
    endcase
    if (!(w_store && w_ram_hit)) begin
      w_ram_be = '0;
    end
  end

  assign w_led_we = w_store && w_led_hit;

  // ---------------------------------------------------------------------------
  // RAM
  // ---------------------------------------------------------------------------
  logic [31:0] w_ram_rdata;

  dmem_ram #(
    .WORDS (RAM_WORDS),
    .AW    (AW)
  ) u_ram (
    .i_clock (clock),
    .i_wrclk (wrclk),
    .i_be    (w_ram_be),
    .i_waddr (w_ram_idx),
    .i_wdata (w_ram_wdata),
    .i_raddr (w_ram_idx),
    .o_rdata (w_ram_rdata)
  );

  // ---------------------------------------------------------------------------
  // LED register (write side lives on wrclk, so its reset is taken there)
  // ---------------------------------------------------------------------------
  logic [31:0] r_led;

  always_ff @(posedge wrclk) begin
    if (reset) begin
      r_led <= '0;
    end else if (w_led_we) begin
      r_led <= datain;
    end
  end

  assign led = r_led[15:0];

  // ---------------------------------------------------------------------------
  // Timer, error flag and read-side registers
  // ---------------------------------------------------------------------------
  logic [31:0] r_timer;
  logic        r_err;
  rd_src_e     r_src;
  logic [31:0] r_mmio;
  logic [2:0]  r_memop;
  logic [1:0]  r_lane;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_timer <= '0;
      r_err   <= 1'b0;
      r_src   <= SRC_NONE;
      r_mmio  <= '0;
      r_memop <= '0;
      r_lane  <= '0;
    end else begin
      r_timer <= r_timer + 32'd1;
      r_memop <= memop;
      r_lane  <= addr[1:0];
      // Timer value captured before this edge's increment.
      r_mmio  <= w_timer_hit ? r_timer : r_led;
      if (!w_access_ok) begin
        r_err <= 1'b1;
        r_src <= SRC_NONE;
      end else if (w_ram_hit) begin
        r_src <= SRC_RAM;
      end else begin
        r_src <= SRC_MMIO;
      end
    end
  end

  assign err = r_err;

  // ---------------------------------------------------------------------------
  // Load extender
  // ---------------------------------------------------------------------------
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_word = '0;
    case (r_src)
      SRC_RAM:  w_word = w_ram_rdata;
      SRC_MMIO: w_word = r_mmio;
      default:  w_word = '0;
    endcase

    w_byte = w_word[7:0];
    case (r_lane)
      2'd1:    w_byte = w_word[15:8];
      2'd2:    w_byte = w_word[23:16];
      2'd3:    w_byte = w_word[31:24];
      default: w_byte = w_word[7:0];
    endcase

    w_half = r_lane[1] ? w_word[31:16] : w_word[15:0];

    // memop bit 2 marks the unsigned variants.
    dataout = w_word;
    case (mop_size(r_memop))
      SZ_B:    dataout = r_memop[2] ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      SZ_H:    dataout = r_memop[2] ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      default: dataout = w_word;
    endcase
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
  import dmem_ctrl_pkg::*;

  localparam int unsigned RW = 32768;
  localparam logic [31:0] RB = 32'h0010_0000;
  localparam logic [31:0] MB = 32'h0020_0000;

  logic        clock  = 1'b0;
  logic        reset  = 1'b1;
  logic        wrclk;
  logic [31:0] addr   = RB;
  logic [31:0] datain = '0;
  logic [2:0]  memop  = MOP_W;
  logic        we     = 1'b0;
  logic [31:0] dataout;
  logic [15:0] led;
  logic        err;

  always #5 clock = ~clock;
  assign wrclk = ~clock;

  dmem_ctrl #(
    .RAM_WORDS (RW),
    .RAM_BASE  (RB),
    .MMIO_BASE (MB)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .wrclk   (wrclk),
    .addr    (addr),
    .datain  (datain),
    .memop   (memop),
    .we      (we),
    .dataout (dataout),
    .led     (led),
    .err     (err)
  );

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: byte-addressed memory, plain counters, spec rules.
  // ---------------------------------------------------------------------------
  logic [7:0]  m_mem   [RW*4];
  bit          m_known [RW*4];
  logic [31:0] m_timer = '0;
  logic [31:0] m_led   = '0;
  logic [31:0] m_dout  = '0;
  bit          m_err   = 1'b0;
  bit          m_dvalid = 1'b0;

  // Timer preload handshake: written by the stimulus, consumed by the model.
  int          pl_seq  = 0;
  int          pl_seen = 0;
  logic [31:0] pl_val  = '0;
  logic [31:0] m_tnow;
  assign m_tnow = (pl_seq != pl_seen) ? pl_val : m_timer;

  function automatic int nbytes(input logic [2:0] op);
    if (op == 3'b000 || op == 3'b100) return 1;
    if (op == 3'b001 || op == 3'b101) return 2;
    return 4;
  endfunction

  // 0 unmapped, 1 RAM, 2 timer, 3 LED
  function automatic int region(input logic [31:0] a);
    if (a >= RB && (a - RB) < 32'(RW*4)) return 1;
    if (a == MB) return 2;
    if (a == MB + 32'd4) return 3;
    return 0;
  endfunction

  function automatic bit access_ok(input logic [31:0] a, input logic [2:0] op);
    int r;
    int nb;
    r  = region(a);
    nb = nbytes(op);
    if (r == 0) return 1'b0;
    if (r >= 2 && nb != 4) return 1'b0;
    return (int'(a[1:0]) % nb) == 0;
  endfunction

  // Returns {valid, value}; valid is 0 when any byte read was never written.
  function automatic logic [32:0] model_read(input logic [31:0] a, input logic [2:0] op);
    logic [31:0] v;
    bit          ok;
    int          nb;
    int          off;
    if (region(a) == 2) return {1'b1, m_tnow};
    if (region(a) == 3) return {1'b1, m_led};
    v   = '0;
    ok  = 1'b1;
    nb  = nbytes(op);
    off = int'(a - RB);
    for (int i = 0; i < nb; i++) begin
      if (m_known[off+i]) v[8*i +: 8] = m_mem[off+i];
      else ok = 1'b0;
    end
    if (!op[2] && nb == 1 && v[7])  v[31:8]  = '1;
    if (!op[2] && nb == 2 && v[15]) v[31:16] = '1;
    return {ok, v};
  endfunction

  always @(posedge clock) begin
    pl_seen <= pl_seq;
    if (reset) begin
      m_timer  <= '0;
      m_err    <= 1'b0;
      m_dout   <= '0;
      m_dvalid <= 1'b1;
    end else begin
      m_timer <= m_tnow + 32'd1;
      if (!access_ok(addr, memop)) begin
        m_err    <= 1'b1;
        m_dout   <= '0;
        m_dvalid <= 1'b1;
      end else begin
        {m_dvalid, m_dout} <= model_read(addr, memop);
      end
    end
  end

  always @(posedge wrclk) begin
    if (reset) begin
      m_led <= '0;
    end else if (we && access_ok(addr, memop)) begin
      if (region(addr) == 1) begin
        for (int i = 0; i < 4; i++) begin
          if (i < nbytes(memop)) begin
            m_mem[int'(addr - RB) + i]   <= datain[8*i +: 8];
            m_known[int'(addr - RB) + i] <= 1'b1;
          end
        end
      end else if (region(addr) == 3) begin
        m_led <= datain;
      end
    end
  end

  // Per-cycle comparison against the model, between clock and wrclk edges.
  always @(posedge clock) begin
    #3;
    if (chk_en) begin
      check("model err", {31'b0, err}, {31'b0, m_err});
      check("model led", {16'b0, led}, {16'b0, m_led[15:0]});
      if (m_dvalid) check("model dataout", dataout, m_dout);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus: inputs change just after wrclk rises and are held through the
  // next clock and wrclk edges; returns 3 time units after the clock edge.
  // ---------------------------------------------------------------------------
  task automatic op(input logic rst, input logic [31:0] a, input logic [31:0] d,
                    input logic [2:0] m, input logic w);
    @(negedge clock);
    #1;
    reset  = rst;
    addr   = a;
    datain = d;
    memop  = m;
    we     = w;
    @(posedge clock);
    #3;
  endtask

  task automatic idle();
    op(1'b0, RB, 32'h0, MOP_W, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    op(1'b1, RB, 32'h0, MOP_W, 1'b0);
    op(1'b1, RB, 32'h0, MOP_W, 1'b0);
    chk_en = 1'b1;
    check("reset dataout", dataout, 32'h0);
    check("reset err", {31'b0, err}, 32'h0);
    check("reset led", {16'b0, led}, 32'h0);

    // Word and byte store/load
    op(1'b0, RB, 32'h8765_4321, MOP_W, 1'b1);
    op(1'b0, RB + 3, 32'h0, MOP_B, 1'b0);
    check("lb +3", dataout, 32'hFFFF_FF87);
    op(1'b0, RB + 3, 32'h0, MOP_BU, 1'b0);
    check("lbu +3", dataout, 32'h0000_0087);
    op(1'b0, RB, 32'h0, MOP_W, 1'b0);
    check("lw +0", dataout, 32'h8765_4321);

    // Halfword store/load
    op(1'b0, RB + 4, 32'h0, MOP_W, 1'b1);
    op(1'b0, RB + 6, 32'hABCD_F00D, MOP_H, 1'b1);
    op(1'b0, RB + 4, 32'h0, MOP_W, 1'b0);
    check("lw +4 after sh", dataout, 32'hF00D_0000);
    op(1'b0, RB + 6, 32'h0, MOP_H, 1'b0);
    check("lh +6", dataout, 32'hFFFF_F00D);
    op(1'b0, RB + 6, 32'h0, MOP_HU, 1'b0);
    check("lhu +6", dataout, 32'h0000_F00D);
    op(1'b0, RB + 5, 32'h1234_56AA, MOP_B, 1'b1);
    op(1'b0, RB + 4, 32'h0, MOP_W, 1'b0);
    check("lw +4 after sb", dataout, 32'hF00D_AA00);
    op(1'b0, RB + 4, 32'h0, MOP_H, 1'b0);
    check("lh +4", dataout, 32'hFFFF_AA00);
    op(1'b0, RB + 6, 32'h0, MOP_BU, 1'b0);
    check("lbu +6", dataout, 32'h0000_000D);
    check("err clean", {31'b0, err}, 32'h0);

    // Misaligned
    op(1'b0, RB + 2, 32'h0, MOP_W, 1'b0);
    check("lw misaligned data", dataout, 32'h0);
    check("lw misaligned err", {31'b0, err}, 32'h1);
    op(1'b0, RB + 2, 32'h5555_5555, MOP_W, 1'b1);
    op(1'b0, RB + 1, 32'h0, MOP_H, 1'b0);
    check("lh misaligned data", dataout, 32'h0);
    op(1'b0, RB, 32'h0, MOP_W, 1'b0);
    check("ram after misaligned sw", dataout, 32'h8765_4321);
    check("err sticky", {31'b0, err}, 32'h1);

    // Unmapped store after reset
    op(1'b1, RB, 32'h0, MOP_W, 1'b0);
    check("err cleared", {31'b0, err}, 32'h0);
    op(1'b0, 32'h0030_0000, 32'hCAFE_BABE, MOP_W, 1'b1);
    check("unmapped sw err", {31'b0, err}, 32'h1);
    op(1'b0, RB, 32'h0, MOP_W, 1'b0);
    check("ram +0 intact", dataout, 32'h8765_4321);
    op(1'b0, RB + 4, 32'h0, MOP_W, 1'b0);
    check("ram +4 intact", dataout, 32'hF00D_AA00);

    // Timer counts clocks since reset
    op(1'b1, RB, 32'h0, MOP_W, 1'b0);
    repeat (10) idle();
    op(1'b0, MB, 32'h0, MOP_W, 1'b0);
    check("timer 10", dataout, 32'd10);
    check("timer err", {31'b0, err}, 32'h0);

    // Timer wrap
    force dut.r_timer = 32'hFFFF_FFFC;
    pl_val = 32'hFFFF_FFFC;
    pl_seq = pl_seq + 1;
    #1;
    release dut.r_timer;
    op(1'b0, MB, 32'h0, MOP_W, 1'b0);
    check("timer fffffffc", dataout, 32'hFFFF_FFFC);
    op(1'b0, MB, 32'h0, MOP_W, 1'b0);
    check("timer fffffffd", dataout, 32'hFFFF_FFFD);
    op(1'b0, MB, 32'h0, MOP_W, 1'b0);
    check("timer fffffffe", dataout, 32'hFFFF_FFFE);
    op(1'b0, MB, 32'h0, MOP_W, 1'b0);
    check("timer ffffffff", dataout, 32'hFFFF_FFFF);
    op(1'b0, MB, 32'h0, MOP_W, 1'b0);
    check("timer wrap 0", dataout, 32'h0);

    // LED register
    op(1'b0, MB + 4, 32'h1234_5678, MOP_W, 1'b1);
    op(1'b0, MB + 4, 32'h0, MOP_W, 1'b0);
    check("led out", {16'b0, led}, 32'h0000_5678);
    check("led readback", dataout, 32'h1234_5678);
    op(1'b0, MB + 4, 32'h0000_00FF, MOP_B, 1'b1);
    check("sb led err", {31'b0, err}, 32'h1);
    check("sb led data", dataout, 32'h0);
    idle();
    check("led unchanged", {16'b0, led}, 32'h0000_5678);

    // Same-instruction read and write
    op(1'b0, RB + 8, 32'h1111_1111, MOP_W, 1'b1);
    op(1'b0, RB + 8, 32'h2222_2222, MOP_W, 1'b1);
    check("read before write", dataout, 32'h1111_1111);
    op(1'b0, RB + 8, 32'h0, MOP_W, 1'b0);
    check("read after write", dataout, 32'h2222_2222);

    // Reset in the cycle of a store
    op(1'b0, RB + 16, 32'h0102_0304, MOP_W, 1'b1);
    op(1'b1, RB + 16, 32'hDEAD_BEEF, MOP_W, 1'b1);
    check("reset-cycle dataout", dataout, 32'h0);
    check("reset-cycle err", {31'b0, err}, 32'h0);
    op(1'b0, MB, 32'h0, MOP_W, 1'b0);
    check("timer after reset", dataout, 32'h0);
    check("led after reset", {16'b0, led}, 32'h0);
    op(1'b0, RB + 16, 32'h0, MOP_W, 1'b0);
    check("store during reset dropped", dataout, 32'h0102_0304);
    op(1'b0, RB, 32'h0, MOP_W, 1'b0);
    check("ram survives reset", dataout, 32'h8765_4321);

    idle();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
# dmem_ctrl

Data-side memory controller for the single-cycle rv32is core. Consumes the core's data-memory port (address, write data, memop, write enable, read/write clocks) and returns load data. Provides byte-enable stores, sign/zero-extended sub-word loads, a word RAM, two memory-mapped registers (free-running cycle timer, LED register), and a sticky access-error flag.

## Interface
Parameters:
- RAM_WORDS, 32768: RAM depth in 32-bit words (128 KB); power of two.
- RAM_BASE, 32'h0010_0000: byte address of RAM word 0.
- MMIO_BASE, 32'h0020_0000: byte address of timer; LED register at MMIO_BASE+4.

Ports:
- clock  in  1  read clock; core drives its dmemrdclk here. Timer, reset and read registers use its rising edge.
- reset  in  1  synchronous, active-high.
- wrclk  in  1  write clock; core drives dmemwrclk (~clock). Stores commit on its rising edge.
- addr  in  32  byte address (core ALU result).
- datain  in  32  store data (core busB).
- memop  in  3  access size/sign, RISC-V funct3 encoding.
- we  in  1  store enable.
- dataout  out  32  load data, extended.
- led  out  16  LED register low half.
- err  out  1  sticky access error.

## Operation
- memop: 000 byte signed, 001 half signed, 010 word, 100 byte unsigned, 101 half unsigned; 011/110/111 treated as word.
- Decode: RAM hit when addr−RAM_BASE < 4·RAM_WORDS; index = (addr−RAM_BASE)[log2(RAM_WORDS)+1:2]. addr==MMIO_BASE: timer (read-only, stores ignored). addr==MMIO_BASE+4: LED register, 32-bit, word access only. Anything else unmapped.
- Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
- Stores (we=1, mapped, aligned): byte writes datain[7:0] into lane addr[1:0]; half writes datain[15:0] into lanes {addr[1],0} and {addr[1],1}; word writes all four lanes. Other lanes unchanged.
- Loads: select lane(s) by registered addr[1:0]; signed ops sign-extend from bit 7/15, unsigned ops zero-extend.
- Misaligned or unmapped access (load, or store with we=1): store suppressed, dataout=0, err set. err clears only on reset.
- Sub-word access to timer/LED: treated as misaligned (err set, store suppressed, load 0).
- Timer: 32-bit, +1 every clock rising edge, wraps 0xFFFF_FFFF→0.

## Timing
- Read: addr/memop sampled at clock rising edge; RAM word and MMIO value latched same edge; dataout valid after that edge, combinational extension from the registered memop/addr[1:0]. The core samples it in the following half cycle.
- Write: commits at wrclk rising edge (half cycle after the clock edge of the same instruction), using addr/datain/memop/we stable at that edge.
- Read and write of the same word in one instruction: load returns pre-store contents.
- Timer read returns the value before that edge's increment.
- Reset (sampled at clock rise): timer=0, LED=0, err=0, registered read data/memop/addr=0, so dataout=0. RAM contents unaffected. While reset is high, stores at wrclk are suppressed, including a store already in flight when reset asserts.
- err sets at the clock edge that samples the bad access.

## Structure
- Shared package: memop codes (MOP_B, MOP_H, MOP_W, MOP_BU, MOP_HU), RAM_BASE and MMIO_BASE defaults, MMIO offsets (TIMER_OFS=0, LED_OFS=4).
- Sub-module dmem_ram: RAM_WORDS×32 array, 4-bit byte-enable write on wrclk, registered read on clock; maps to block RAM.
- Top level holds the decoder, lane steering, load extender, timer, LED register and err.

## Test plan
- Word and byte store/load: sw 0x8765_4321 @0x0010_0000; lb @0x0010_0003 → 0xFFFF_FF87; lbu @…03 → 0x0000_0087; lw → 0x8765_4321.
- Halfword store/load: sh 0xABCD_F00D @0x0010_0006 over 0x0; lw @…04 → 0xF00D_0000; lh @…06 → 0xFFFF_F00D; lhu @…06 → 0x0000_F00D.
- Misaligned and unmapped: lw @0x0010_0002 → dataout 0, err=1, RAM unchanged; after reset, sw @0x0030_0000 → err=1, no RAM word changed.
- MMIO: after reset release, 10 clocks, lw @0x0020_0000 → 10. Timer preloaded near 0xFFFF_FFFF wraps to 0. sw 0x1234_5678 @0x0020_0004 → led=0x5678; sb to the same address → err=1, led unchanged.
- Same-instruction read and write: word holds 0x1111_1111; lw/sw 0x2222_2222 in the same cycle → load 0x1111_1111; next lw → 0x2222_2222.
- Reset mid-operation: assert reset in the cycle of sw 0xDEAD_BEEF @0x0010_0010 → word keeps its prior value; dataout, led, err, timer all 0; previously written RAM data survives reset.
